// File: rtl/hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module   : hvsync_generator
// Purpose  : Raster timing generator (pixel/line counters plus sync decode).
// Revision : 1.0 - initial release
// ============================================================================
module hvsync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam logic [9:0] c_h_display    = 10'(H_DISPLAY);
  localparam logic [9:0] c_h_max        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_h_sync_start = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] c_h_sync_end   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_v_display    = 10'(V_DISPLAY);
  localparam logic [9:0] c_v_max        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [9:0] c_v_sync_start = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] c_v_sync_end   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic       w_line_end;

  assign w_line_end = (r_hpos == c_h_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos <= 10'd0;
      r_vpos <= 10'd0;
    end else begin
      r_hpos <= w_line_end ? 10'd0 : r_hpos + 10'd1;
      // Line counter advances only on the last pixel of a line.
      if (w_line_end) begin
        r_vpos <= (r_vpos == c_v_max) ? 10'd0 : r_vpos + 10'd1;
      end
    end
  end

  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign hsync      = !((r_hpos >= c_h_sync_start) && (r_hpos <= c_h_sync_end));
  assign vsync      = !((r_vpos >= c_v_sync_start) && (r_vpos <= c_v_sync_end));
  assign display_on = (r_hpos < c_h_display) && (r_vpos < c_v_display);

endmodule
`default_nettype wire

// File: tb/tb_hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hvsync_generator
// Purpose  : Directed vector bench for a default-timing and a compact-timing instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hvsync_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w_hs0, w_vs0, w_de0;
  logic [9:0] w_hp0, w_vp0;
  logic       w_hs1, w_vs1, w_de1;
  logic [9:0] w_hp1, w_vp1;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  hvsync_generator u_dut_vga (
    .clk(clk), .reset(reset), .hsync(w_hs0), .vsync(w_vs0),
    .display_on(w_de0), .hpos(w_hp0), .vpos(w_vp0)
  );

  // Compact timing: 15 clocks/line (H_MAX 14, hsync 10..12), 13 lines (V_MAX 12, vsync 8..9)
  hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
  ) u_dut_small (
    .clk(clk), .reset(reset), .hsync(w_hs1), .vsync(w_vs1),
    .display_on(w_de1), .hpos(w_hp1), .vpos(w_vp1)
  );

  typedef struct {
    string      name;
    bit         dut;
    int         cyc;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic check(input string name, input bit dut, input logic [9:0] eh, input logic [9:0] ev,
                       input logic ehs, input logic evs, input logic ede);
    logic [9:0] ah, av;
    logic       ahs, avs, ade;
    ah  = dut ? w_hp1 : w_hp0;
    av  = dut ? w_vp1 : w_vp0;
    ahs = dut ? w_hs1 : w_hs0;
    avs = dut ? w_vs1 : w_vs0;
    ade = dut ? w_de1 : w_de0;
    checks++;
    if ({ah, av, ahs, avs, ade} !== {eh, ev, ehs, evs, ede}) begin
      errors++;
      $display("FAIL %s dut%0d: got h=%0d v=%0d hs=%b vs=%b de=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b",
               name, dut, ah, av, ahs, avs, ade, eh, ev, ehs, evs, ede);
    end
  endtask

  initial begin
    // Default timing: cycle = vpos*800 + hpos
    vecs.push_back('{"rst_state",   1'b0,   0,   0, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"first_tick",  1'b0,   1,   1, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"de_last",     1'b0, 639, 639, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"de_off",      1'b0, 640, 640, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"hs_before",   1'b0, 655, 655, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"hs_start",    1'b0, 656, 656, 0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"hs_end",      1'b0, 751, 751, 0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"hs_after",    1'b0, 752, 752, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"line_end",    1'b0, 799, 799, 0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"line_wrap",   1'b0, 800,   0, 1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"line1_tick",  1'b0, 801,   1, 1, 1'b1, 1'b1, 1'b1});
    // Compact timing: cycle = vpos*15 + hpos
    vecs.push_back('{"s_rst",       1'b1,   0,  0,  0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"s_line_end",  1'b1,  14, 14,  0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_line_wrap", 1'b1,  15,  0,  1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"s_de_last",   1'b1,  82,  7,  5, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"s_de_vblank", 1'b1,  90,  0,  6, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_hs_v7",     1'b1, 116, 11,  7, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"s_vs_before", 1'b1, 119, 14,  7, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_vs_start",  1'b1, 120,  0,  8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"s_vs_hs",     1'b1, 131, 11,  8, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"s_vs_end",    1'b1, 149, 14,  9, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"s_vs_after",  1'b1, 150,  0, 10, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_frame_end", 1'b1, 194, 14, 12, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"s_frame_wrap",1'b1, 195,  0,  0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{"s_frame_tick",1'b1, 196,  1,  0, 1'b1, 1'b1, 1'b1});

    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].cyc < cur) do_reset();
      while (cur < vecs[i].cyc) step();
      check(vecs[i].name, vecs[i].dut, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].de);
    end

    // Mid-frame reset, held for two edges, then resume from the origin
    do_reset();
    repeat (110) step();
    check("mid_pre_small", 1'b1,  5, 7, 1'b1, 1'b1, 1'b0);
    check("mid_pre_vga",   1'b0, 110, 0, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_small", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_vga",   1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("mid_hold_small", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    step();
    check("resume_small", 1'b1, 1, 0, 1'b1, 1'b1, 1'b1);
    check("resume_vga",   1'b0, 1, 0, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
